// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Purpose  : Operand-issue / result-capture stage around a 16-bit combinational
//            alu, with valid/ready handshakes, Z/N/C/V flags and an accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   ACC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_use_acc,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_o,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] acc_q;
    logic             out_valid_q;

    logic             w_accept;
    logic             w_z, w_n, w_c, w_v;

    // in_ready depends combinationally on out_ready only, never on in_valid.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    state_d  = in_valid ? S_EXEC : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    assign w_accept = in_valid & in_ready;

    // Overflow checks use the registered operands, which are what the alu saw.
    always_comb begin
        w_z = (alu_o == '0);
        w_n = alu_o[WIDTH-1];
        w_c = 1'b0;
        w_v = 1'b0;
        if (op_q == c_OP_ADD) begin
            w_c = alu_cout;
            w_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (alu_o[WIDTH-1] != a_q[WIDTH-1]);
        end else if (op_q == c_OP_SUB) begin
            w_c = alu_cout;
            w_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (alu_o[WIDTH-1] != a_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            acc_q       <= ACC_RESET;
            out_valid_q <= 1'b0;
        end else begin
            if (w_accept) begin
                op_q <= in_op;
                // In DONE, acc_q already holds the result being retired this cycle.
                a_q  <= in_use_acc ? acc_q : in_a;
                b_q  <= in_b;
            end
            if (state_q == S_EXEC) begin
                result_q    <= alu_o;
                flags_q     <= {w_z, w_n, w_c, w_v};
                acc_q       <= alu_o;
                out_valid_q <= 1'b1;
            end else if ((state_q == S_DONE) && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_flags  = flags_q;
    assign acc        = acc_q;

endmodule

`default_nettype wire
